// File: rtl/led_pwm_breath.sv
// Single-LED PWM with optional automatic breathing fade, stepped by an external
// slow tick that is synchronized and edge-detected onto clk_i.
module led_pwm_breath #(
  parameter int CNT_W        = 8,
  parameter int FADE_STEP    = 1,
  parameter int HOLD_PERIODS = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             breathe_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o,
  output logic [CNT_W-1:0] duty_o,
  output logic             period_o
);

  localparam int               HOLD_W    = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [CNT_W:0]   MAX       = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]   STEP      = (CNT_W+1)'(FADE_STEP);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_PERIODS - 1);

  typedef enum logic [2:0] {ST_STATIC, ST_UP, ST_HOLD_HI, ST_DOWN, ST_HOLD_LO} state_t;

  logic              r_s1, r_s2, r_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_duty;
  logic [HOLD_W-1:0] r_hold;
  state_t            r_state;
  logic              r_pwm, r_bnd, r_period;

  logic              w_step, w_wrap;
  logic [CNT_W:0]    w_up, w_dn;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_duty_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;

  assign w_step = r_s2 & ~r_d & en_i;
  assign w_wrap = w_step & (r_cnt == '1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_d      <= 1'b0;
      r_cnt    <= '0;
      r_pwm    <= 1'b0;
      r_bnd    <= 1'b0;
      r_period <= 1'b0;
    end else begin
      r_s1     <= tick_i;
      r_s2     <= r_s1;
      r_d      <= r_s2;
      if (w_step) r_cnt <= r_cnt + 1'b1;
      // Compares the registered count/duty, so pwm_o trails a count change by one edge.
      r_pwm    <= en_i & (r_cnt < r_duty);
      r_bnd    <= w_wrap;
      r_period <= r_bnd;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_STATIC;
      r_duty  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Everything below only moves on the wrap step, so duty never changes mid-period.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_hold_nxt  = r_hold;
    w_up        = {1'b0, r_duty} + STEP;
    w_dn        = {1'b0, r_duty} - STEP;
    if (w_wrap) begin
      if (!breathe_i) begin
        w_state_nxt = ST_STATIC;
        w_duty_nxt  = duty_i;
      end else begin
        case (r_state)
          ST_STATIC: begin
            w_duty_nxt  = duty_i;
            w_state_nxt = ST_UP;
          end
          ST_UP: begin
            if (w_up >= MAX) begin
              w_duty_nxt  = '1;
              w_state_nxt = ST_HOLD_HI;
              w_hold_nxt  = HOLD_INIT;
            end else begin
              w_duty_nxt  = w_up[CNT_W-1:0];
            end
          end
          ST_HOLD_HI: begin
            if (r_hold == '0) w_state_nxt = ST_DOWN;
            else              w_hold_nxt  = r_hold - 1'b1;
          end
          ST_DOWN: begin
            if ({1'b0, r_duty} <= STEP) begin
              w_duty_nxt  = '0;
              w_state_nxt = ST_HOLD_LO;
              w_hold_nxt  = HOLD_INIT;
            end else begin
              w_duty_nxt  = w_dn[CNT_W-1:0];
            end
          end
          ST_HOLD_LO: begin
            if (r_hold == '0) w_state_nxt = ST_UP;
            else              w_hold_nxt  = r_hold - 1'b1;
          end
          default: w_state_nxt = ST_STATIC;
        endcase
      end
    end
  end

  assign pwm_o    = r_pwm;
  assign duty_o   = r_duty;
  assign period_o = r_period;

endmodule

// File: tb/tb_led_pwm_breath.sv
// Bench for led_pwm_breath: a saturating fast-fade instance (A) driven from a
// per-period vector table, and a small slow-fade instance (B) left breathing.
module tb_led_pwm_breath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic       brth_a = 1'b0;
  logic       brth_b = 1'b1;
  logic [7:0] duty_a = 8'd0;
  logic [3:0] duty_b = 4'd0;
  logic       pwm_a, per_a, pwm_b, per_b;
  logic [7:0] dout_a;
  logic [3:0] dout_b;

  always #5 clk = ~clk;

  led_pwm_breath #(.CNT_W(8), .FADE_STEP(100), .HOLD_PERIODS(4)) u_a (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .en_i(en), .breathe_i(brth_a),
    .duty_i(duty_a), .pwm_o(pwm_a), .duty_o(dout_a), .period_o(per_a));

  led_pwm_breath #(.CNT_W(4), .FADE_STEP(1), .HOLD_PERIODS(3)) u_b (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .en_i(en), .breathe_i(brth_b),
    .duty_i(duty_b), .pwm_o(pwm_b), .duty_o(dout_b), .period_o(per_b));

  typedef struct {
    int hi;     // tick high/low length in clk cycles
    bit br;     // breathe_i for instance A
    int din;    // duty_i at period start
    int mid;    // duty_i written at step 128 (-1: none)
    int frz;    // step index where en_i is dropped (-1: none)
    int dnext;  // duty A must load at the boundary ending this period
  } vec_t;

  typedef struct {
    bit pwm; int duty; bit per;
    bit bpwm; int bduty; bit bper;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_cnt = 8'd0;
  int   exp_duty = 0;
  int   kb = -1;
  int   exp_bd = 0;
  bit   smp_pwm[4];
  bit   smp_per[4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instance B breathes 0..15 with step 1 and 3 hold periods; k counts its boundaries.
  function automatic int bduty_of(input int k);
    int j;
    if (k <= 0) return 0;
    j = (k - 1) % 36;
    if (j < 15) return j + 1;
    if (j < 18) return 15;
    if (j < 33) return 14 - (j - 18);
    return 0;
  endfunction

  task automatic add(input int hi, input bit br, input int din, input int mid,
                     input int frz, input int dnext);
    vec_t v;
    v.hi = hi; v.br = br; v.din = din; v.mid = mid; v.frz = frz; v.dnext = dnext;
    tbl.push_back(v);
  endtask

  // One tick: rise sampled at edge k; outputs are checked after edge k+3.
  task automatic do_step(input int hi, input int lo, input int dnext);
    exp_t e;
    if (exp_cnt == 8'hFF) exp_duty = dnext;
    exp_cnt++;
    if (exp_cnt[3:0] == 4'd0) begin
      kb++;
      exp_bd = bduty_of(kb);
    end
    e.pwm   = (int'(exp_cnt) < exp_duty);
    e.duty  = exp_duty;
    e.per   = (exp_cnt == 8'd0);
    e.bpwm  = (int'(exp_cnt[3:0]) < exp_bd);
    e.bduty = exp_bd;
    e.bper  = (exp_cnt[3:0] == 4'd0);
    sb.push_back(e);
    tick = 1'b1;
    for (int i = 0; i < hi + lo; i++) begin
      if (i == hi) tick = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        smp_pwm[i] = pwm_a;
        smp_per[i] = per_a;
      end
      if (i == 3) begin
        e = sb.pop_front();
        chk("a_pwm",    int'(pwm_a),  int'(e.pwm));
        chk("a_duty",   int'(dout_a), e.duty);
        chk("a_period", int'(per_a),  int'(e.per));
        chk("b_pwm",    int'(pwm_b),  int'(e.bpwm));
        chk("b_duty",   int'(dout_b), e.bduty);
        chk("b_period", int'(per_b),  int'(e.bper));
      end
    end
  endtask

  task automatic freeze();
    bit hi_seen = 0;
    bit per_seen = 0;
    en = 1'b0;
    @(negedge clk);
    chk("frz_pwm_next_edge", int'(pwm_a), 0);
    repeat (100) begin
      tick = 1'b1;
      repeat (5) begin @(negedge clk); if (pwm_a) hi_seen = 1; if (per_a) per_seen = 1; end
      tick = 1'b0;
      repeat (5) begin @(negedge clk); if (pwm_a) hi_seen = 1; if (per_a) per_seen = 1; end
    end
    chk("frz_pwm_stays_low", int'(hi_seen), 0);
    chk("frz_no_period", int'(per_seen), 0);
    chk("frz_duty_held", int'(dout_a), exp_duty);
    chk("frz_b_duty_held", int'(dout_b), exp_bd);
    en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Records: hi, breathe, duty_i, mid duty_i, freeze step, expected next duty
    add(5, 0, 64,  -1, -1, 64);
    add(2, 0, 64,  -1, -1, 64);
    add(2, 0, 64, 200, -1, 200);
    add(2, 0, 0,   -1, -1, 0);
    add(2, 1, 0,   -1, -1, 0);
    add(2, 1, 0,   -1, -1, 100);
    add(2, 1, 0,   -1, 50, 200);
    add(2, 1, 0,   -1, -1, 255);
    for (int i = 0; i < 4; i++) add(2, 1, 0, -1, -1, 255);
    add(2, 1, 0,   -1, -1, 155);
    add(2, 1, 0,   -1, -1, 55);
    add(2, 1, 0,   -1, -1, 0);
    for (int i = 0; i < 4; i++) add(2, 1, 0, -1, -1, 0);
    add(2, 1, 0,   -1, -1, 100);
    add(2, 1, 0,   -1, -1, 200);
    add(2, 1, 0,   -1, -1, 255);
    for (int i = 0; i < 4; i++) add(2, 1, 0, -1, -1, 255);
    add(2, 1, 0,   -1, -1, 155);
    add(2, 0, 10,  -1, -1, 10);
    add(2, 0, 10,  -1, -1, 10);

    repeat (3) @(negedge clk);
    chk("rst_pwm",    int'(pwm_a),  0);
    chk("rst_duty",   int'(dout_a), 0);
    chk("rst_period", int'(per_a),  0);
    chk("rst_b_duty", int'(dout_b), 0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    foreach (tbl[r]) begin
      brth_a = tbl[r].br;
      duty_a = 8'(tbl[r].din);
      for (int s = 0; s < 256; s++) begin
        if (s == 128 && tbl[r].mid >= 0) duty_a = 8'(tbl[r].mid);
        if (s == tbl[r].frz) freeze();
        do_step(tbl[r].hi, tbl[r].hi, tbl[r].dnext);
      end
    end

    // Count latency: pwm still reflects cnt=9 after edge k+2, drops after k+3.
    for (int s = 0; s < 9; s++) do_step(2, 2, 10);
    do_step(2, 2, 10);
    chk("lat_pwm_k1", int'(smp_pwm[1]), 1);
    chk("lat_pwm_k2", int'(smp_pwm[2]), 1);
    chk("lat_pwm_k3", int'(smp_pwm[3]), 0);
    for (int s = 0; s < 245; s++) do_step(2, 2, 10);
    do_step(2, 2, 10);
    chk("lat_period_k2", int'(smp_per[2]), 0);
    chk("lat_period_k3", int'(smp_per[3]), 1);
    do_step(2, 2, 10);
    chk("period_one_cycle", int'(smp_per[0]), 0);

    // Asynchronous reset while pwm is high and duty is 10.
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pwm",    int'(pwm_a),  0);
    chk("async_rst_duty",   int'(dout_a), 0);
    chk("async_rst_period", int'(per_a),  0);
    chk("async_rst_b_duty", int'(dout_b), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0; exp_duty = 0; kb = -1; exp_bd = 0;
    @(negedge clk);
    for (int s = 0; s < 272; s++) do_step(2, 2, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_breath.md
# led_pwm_breath

PWM generator with automatic "breathing" fade for one Nexys LED, directly downstream of `clk_devider`. It consumes `clk_devider`'s `clk_o` as a step tick, runs an N-bit PWM counter, and produces the LED drive signal. Duty comes either from a static input or from an internal fade state machine. All logic runs on the board clock. The tick is synchronized and edge-detected internally, never used as a clock.

## Interface
- `CNT_W`, default 8: PWM counter and duty width; PWM period is 2^CNT_W steps.
- `FADE_STEP`, default 1: duty increment or decrement applied per PWM period while fading.
- `HOLD_PERIODS`, default 16: number of PWM periods spent at full and at zero duty before reversing.

Ports:
- `clk_i`, in, 1: system clock; all flops on the rising edge.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `tick_i`, in, 1: `clk_o` from `clk_devider`; asynchronous level; each rising edge is one PWM step.
- `en_i`, in, 1: 1 = run; 0 = freeze the counter and FSM and force `pwm_o` low.
- `breathe_i`, in, 1: 1 = automatic fade; 0 = static duty taken from `duty_i`.
- `duty_i`, in, CNT_W: static duty value.
- `pwm_o`, out, 1: LED drive (registered).
- `duty_o`, out, CNT_W: duty currently applied.
- `period_o`, out, 1: one-`clk_i` pulse per PWM period wrap.

## Operation
- **Tick input:** `tick_i` passes through a 2-FF synchronizer (s1, s2) plus a delay flop d. `step = s2 & ~d`. Steps are ignored while `en_i`=0.
- **Counter (`cnt`):**
  - On a step, `cnt` increments, wrapping from 2^CNT_W−1 to 0.
  - The wrap step is the period boundary. `period_o` pulses for exactly one cycle, registered, on the edge after the wrap.
- **Output:** `pwm_o` is registered as `en_i & (cnt < duty)`.
  - duty=0 gives a constant low.
  - duty=2^CNT_W−1 gives high for 255 of every 256 steps (CNT_W=8).
- **Duty updates:** `duty` (= `duty_o`) changes only at a period boundary, so `pwm_o` never glitches mid-period.
- **FSM:** states are STATIC, UP, HOLD_HI, DOWN, HOLD_LO. All transitions and duty/hold updates are evaluated only at period boundaries.
  - **STATIC:** duty ← `duty_i`. If `breathe_i`=1, go to UP.
  - **UP:** duty ← min(duty+FADE_STEP, MAX). When the new duty equals MAX, go to HOLD_HI and set hold ← HOLD_PERIODS−1.
  - **HOLD_HI:** if hold=0, go to DOWN; otherwise hold decrements.
  - **DOWN:** duty ← max(duty−FADE_STEP, 0), saturating with no underflow. At 0, go to HOLD_LO and set hold ← HOLD_PERIODS−1.
  - **HOLD_LO:** if hold=0, go to UP; otherwise hold decrements.
  - **`breathe_i`=0 in any fade state:** go to STATIC at the next boundary and load `duty_i` at that same boundary.
- **Fade start:** entering UP from STATIC starts from the current duty. No reset to 0.
- **Width rules:** duty arithmetic uses CNT_W+1 bits before saturation. hold is ceil(log2(HOLD_PERIODS)) bits wide, minimum 1.
- **Reset values:** s1/s2/d=0, `cnt`=0, duty=0, hold=0, state=STATIC, `pwm_o`=0, `period_o`=0.

## Timing
- `tick_i` must stay high ≥2 and low ≥2 `clk_i` cycles; minimum tick period is 4 `clk_i` cycles.
- Latency from a `tick_i` rise sampled at edge k:
  - `cnt` changes at edge k+2.
  - `pwm_o` and `period_o` reflect that change at edge k+3.
- **`en_i` falling:** `pwm_o` is 0 at the next edge. `cnt`, duty, state and hold hold their values.
- **`en_i` rising:** operation resumes from the frozen values. A tick edge already in the synchronizer still counts as a step only if `en_i`=1 in the step cycle.
- **Simultaneous events:**
  - A `breathe_i` change is acted on only at a boundary.
  - A `duty_i` change mid-period takes effect at the next boundary.
- **Reset mid-operation:** all registers clear immediately, independent of the clock. After deassertion, the first step yields `cnt`=1.
- A full fade cycle with CNT_W=8, FADE_STEP=1, HOLD_PERIODS=16 lasts 255+16+255+16 = 542 periods.

## Test plan
1. **Reset and latency:** assert `rst_i` mid-run, then `duty_i`=0, `breathe_i`=0, `en_i`=1, `tick_i` toggling every 5 clk. Required: all outputs 0 during reset; `pwm_o` stays 0; `period_o` pulses once per 256 steps; `cnt` moves on the 3rd edge after each tick rise.
2. **Static duty:** `duty_i`=64. Required: from the second period onward, `pwm_o` is high for exactly 64 of 256 steps; `duty_o`=64. Change `duty_i` to 200 mid-period: the current period keeps 64 and the next period shows 200.
3. **Breathing:** `breathe_i`=1 from duty 0, FADE_STEP=1, HOLD_PERIODS=16. Required: `duty_o` rises by 1 per period to 255, holds 16 periods, falls to 0, holds 16 periods, and repeats; never exceeds 255 or goes below 0.
4. **Saturation:** FADE_STEP=100. Required: duty sequence 0, 100, 200, 255 (HOLD_HI), …, 255, 155, 55, 0 (HOLD_LO).
5. **Enable freeze:** drop `en_i` for 1000 clk in the middle of UP. Required: `pwm_o` goes low one edge later; `cnt`, `duty_o` and state are unchanged; the fade continues from the same duty after re-enable.
6. **Mode exit:** drop `breathe_i` during DOWN with `duty_i`=10. Required: STATIC at the next boundary with `duty_o`=10; no intermediate duty value appears.
